// File: rtl/cpu_pkg.sv
// Shared definitions for the unified memory arbiter: state encoding and
// the default completion timeout.
package cpu_pkg;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 64;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_I,
    WAIT_I,
    ISSUE_D,
    WAIT_D
  } arb_state_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait-cycle counter for the arbiter: cleared at issue, counts cycles spent
// waiting for memory, and flags expiry once TIMEOUT-1 is reached.
module arb_wait_timer #(
  parameter int unsigned TIMEOUT = cpu_pkg::ARB_TIMEOUT_DEFAULT,
  parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Saturates at LAST so a missed exit can never wrap back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the fetch and memory stages onto one single-port memory, one
// transaction at a time, with data-port priority and a completion timeout.
module unified_mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  output logic          stall_F,
  output logic          stall_M,
  output logic          err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  arb_state_t state;
  logic       in_wait_i;
  logic       in_wait_d;
  logic       waiting;
  logic       expired;
  logic       timed_out;
  logic       finish;

  assign in_wait_i = (state == WAIT_I);
  assign in_wait_d = (state == WAIT_D);
  assign waiting   = in_wait_i | in_wait_d;
  assign timed_out = waiting & ~mem_done & expired;
  assign finish    = waiting & (mem_done | expired);

  arb_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state == ISSUE_I) | (state == ISSUE_D)),
    .enable  (waiting & ~mem_done),
    .expired (expired)
  );

  // A flushed fetch still lets the memory finish, but its ack is swallowed.
  assign if_ack   = in_wait_i & finish & if_req;
  assign d_ack    = in_wait_d & finish;
  assign if_rdata = (if_ack && !timed_out) ? mem_rdata : '0;
  assign d_rdata  = (d_ack && !timed_out) ? mem_rdata : '0;
  assign stall_F  = if_req & ~if_ack;
  assign stall_M  = d_req & ~d_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req) begin
            state     <= ISSUE_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
          end else if (if_req) begin
            state    <= ISSUE_I;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end
        end
        ISSUE_I: state <= WAIT_I;
        ISSUE_D: state <= WAIT_D;
        // On completion only the opposite port is considered; the finishing
        // port's request is still asserted this cycle and must not re-win.
        WAIT_I: begin
          if (timed_out) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (mem_done) begin
            if (d_req) begin
              state     <= ISSUE_D;
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state <= IDLE;
            end
          end
        end
        WAIT_D: begin
          if (timed_out) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (mem_done) begin
            if (if_req) begin
              state    <= ISSUE_I;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
